// File: rtl/demux4_buf_pkg.sv
// Shared definitions for the 4-way demultiplexer and its companion 4-way selector.
// Holds width defaults, the channel-select encoding and the slot state type.
package demux4_buf_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT  = 8;
  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned SEL_W          = 2;

  // Channel-select encoding, shared with the 4-way selector
  localparam logic [SEL_W-1:0] SEL_CH0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CH1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_CH2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_CH3 = 2'b11;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux4_buf_if.sv
// Handshake bundle for demux4_buf.
//   in_valid/in_ready/in_sel/in_data : producer side, one word tagged with a destination
//   out_valid/out_ready              : per-channel handshake, bit i is channel i
//   out_data                         : channel i word at [i*DATA_W +: DATA_W]
//   out_cnt                          : channel i saturating delivered count at [i*CNT_W +: CNT_W]
// slave is the demux side, master is the producer/consumer side.
interface demux4_buf_if
  import demux4_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
);

  logic                       in_valid;
  logic                       in_ready;
  logic [SEL_W-1:0]           in_sel;
  logic [DATA_W-1:0]          in_data;
  logic [NUM_CH-1:0]          out_valid;
  logic [NUM_CH-1:0]          out_ready;
  logic [NUM_CH*DATA_W-1:0]   out_data;
  logic [NUM_CH*CNT_W-1:0]    out_cnt;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );

endinterface

// File: rtl/demux4_buf_slot.sv
// One demux channel slot: a single-entry word register with load and drain plus a
// saturating delivered-word counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : write load_data this cycle (channel goes full)
//   load_data  : word to store
//   ready      : consumer takes the held word this cycle
//   valid      : slot holds a word
//   data       : held word (last value kept once drained)
//   cnt        : number of words delivered, saturating
module demux4_buf_slot
  import demux4_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              drain;

  assign valid = (state_q == StFull);
  assign data  = data_q;
  assign cnt   = cnt_q;
  assign drain = valid & ready;

  // A load wins over a drain: the old word leaves while the new one lands.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = StFull;
    end else if (drain) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= load_data;
      end
      if (drain && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

endmodule

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer with per-channel one-word buffering.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : demux4_buf_if slave; input word + destination, four output channels
//           with data and saturating delivered counts
// A stalled channel only blocks words addressed to itself.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  demux4_buf_if.slave bus
);

  logic [NUM_CH-1:0] valid;
  logic [NUM_CH-1:0] load;
  logic [DATA_W-1:0] slot_data [NUM_CH];
  logic [CNT_W-1:0]  slot_cnt  [NUM_CH];
  logic              in_fire;

  // Only the addressed channel gates acceptance.
  assign bus.in_ready = !reset & (!valid[bus.in_sel] | bus.out_ready[bus.in_sel]);
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = valid;

  always_comb begin
    load = '0;
    if (in_fire) begin
      unique case (bus.in_sel)
        SEL_CH0: load[0] = 1'b1;
        SEL_CH1: load[1] = 1'b1;
        SEL_CH2: load[2] = 1'b1;
        SEL_CH3: load[3] = 1'b1;
        default: load = '0;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux4_buf_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .load_data (bus.in_data),
      .ready     (bus.out_ready[i]),
      .valid     (valid[i]),
      .data      (slot_data[i]),
      .cnt       (slot_cnt[i])
    );
  end

  always_comb begin
    bus.out_data = '0;
    bus.out_cnt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.out_data[i*DATA_W +: DATA_W] = slot_data[i];
      bus.out_cnt[i*CNT_W +: CNT_W]    = slot_cnt[i];
    end
  end

endmodule

// File: tb/tb_demux4_buf.sv
// Directed self-checking bench for demux4_buf (DATA_W=32, CNT_W=4).
module tb_demux4_buf;
  import demux4_buf_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  demux4_buf_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  demux4_buf #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so inputs change and outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
    tick();
    tick();

    // Reset state
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_cnt", 64'(bus.out_cnt), 64'd0);
    check_eq("rst_out_data_lo", 64'(bus.out_data[63:0]), 64'd0);
    check_eq("rst_out_data_hi", 64'(bus.out_data[127:64]), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_sel = 2'(i);
      #1;
      check_eq("first_in_ready", 64'(bus.in_ready), 64'd1);
    end

    // Reset mid-traffic: word in ch1 is discarded
    bus.in_valid = 1'b1;
    bus.in_sel   = SEL_CH1;
    bus.in_data  = 32'hDEAD_BEEF;
    tick();
    bus.in_valid = 1'b0;
    check_eq("mid_valid_before", 64'(bus.out_valid), 64'h2);
    check_eq("mid_data_before", 64'(bus.out_data[32 +: 32]), 64'hDEAD_BEEF);
    reset = 1'b1;
    #1;
    check_eq("mid_in_ready_rst", 64'(bus.in_ready), 64'd0);
    tick();
    check_eq("mid_valid_after", 64'(bus.out_valid), 64'd0);
    check_eq("mid_cnt_after", 64'(bus.out_cnt), 64'd0);
    check_eq("mid_data_after", 64'(bus.out_data[32 +: 32]), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("mid_in_ready_rel", 64'(bus.in_ready), 64'd1);

    // Single transfer to ch2
    bus.in_valid  = 1'b1;
    bus.in_sel    = SEL_CH2;
    bus.in_data   = 32'h1234_5678;
    bus.out_ready = 4'b0100;
    tick();
    bus.in_valid = 1'b0;
    check_eq("single_valid", 64'(bus.out_valid), 64'h4);
    check_eq("single_data", 64'(bus.out_data[64 +: 32]), 64'h1234_5678);
    tick();
    check_eq("single_valid_after", 64'(bus.out_valid), 64'd0);
    check_eq("single_cnt", 64'(bus.out_cnt), 64'h0100);

    // Stalled channel isolation
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_sel    = SEL_CH0;
    bus.in_data   = 32'h1111_1111;
    tick();
    bus.in_data = 32'h2222_2222;
    #1;
    check_eq("stall_in_ready_ch0", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 4'b0001;
    #1;
    check_eq("stall_in_ready_drain", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 4'b0000;
    tick();
    check_eq("stall_ch0_kept", 64'(bus.out_data[0 +: 32]), 64'h1111_1111);
    bus.in_sel  = SEL_CH3;
    bus.in_data = 32'hA5A5_A5A5;
    #1;
    check_eq("stall_in_ready_ch3", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check_eq("stall_valid", 64'(bus.out_valid), 64'h9);
    check_eq("stall_ch3_data", 64'(bus.out_data[96 +: 32]), 64'hA5A5_A5A5);
    check_eq("stall_ch0_data", 64'(bus.out_data[0 +: 32]), 64'h1111_1111);
    bus.out_ready = 4'b1001;
    tick();
    check_eq("stall_valid_after", 64'(bus.out_valid), 64'd0);
    check_eq("stall_cnt", 64'(bus.out_cnt), 64'h1101);

    // Pass-through stream of 1..8 into ch1
    do_reset();
    bus.out_ready = 4'b0010;
    bus.in_valid  = 1'b1;
    bus.in_sel    = SEL_CH1;
    for (int k = 1; k <= 8; k++) begin
      bus.in_data = 32'(k);
      #1;
      check_eq("pt_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      check_eq("pt_valid", 64'(bus.out_valid), 64'h2);
      check_eq("pt_data", 64'(bus.out_data[32 +: 32]), 64'(k));
    end
    bus.in_valid = 1'b0;
    tick();
    check_eq("pt_valid_after", 64'(bus.out_valid), 64'd0);
    check_eq("pt_cnt", 64'(bus.out_cnt), 64'h0080);

    // Simultaneous drains on all four channels
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_sel  = 2'(i);
      bus.in_data = 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    check_eq("sim_valid", 64'(bus.out_valid), 64'hF);
    check_eq("sim_data0", 64'(bus.out_data[0 +: 32]), 64'd0);
    check_eq("sim_data1", 64'(bus.out_data[32 +: 32]), 64'd1);
    check_eq("sim_data2", 64'(bus.out_data[64 +: 32]), 64'd2);
    check_eq("sim_data3", 64'(bus.out_data[96 +: 32]), 64'd3);
    bus.out_ready = 4'b1111;
    tick();
    check_eq("sim_valid_after", 64'(bus.out_valid), 64'd0);
    check_eq("sim_cnt", 64'(bus.out_cnt), 64'h1111);

    // Counter saturation on ch3: 20 deliveries with CNT_W=4
    do_reset();
    bus.out_ready = 4'b1000;
    bus.in_valid  = 1'b1;
    bus.in_sel    = SEL_CH3;
    for (int k = 1; k <= 20; k++) begin
      bus.in_data = 32'(k + 100);
      tick();
      // k words loaded, k-1 delivered so far
      if (k == 16) check_eq("sat_cnt_15", 64'(bus.out_cnt), 64'hF000);
    end
    bus.in_valid = 1'b0;
    tick();
    check_eq("sat_valid_after", 64'(bus.out_valid), 64'd0);
    check_eq("sat_cnt_20", 64'(bus.out_cnt), 64'hF000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
